imm_gen_pipe: RTL

Pipelined, parameterised immediate generator for the decode stage. It accepts a 32-bit instruction word and a format select over a valid/ready handshake. One cycle later it presents the sign- or zero-extended immediate at XLEN width. A two-entry skid buffer lets decode back-pressure without a combinational ready path to fetch. It also supports a flush from branch resolution and a saturating count of illegal format selects for debug.

---
 rtl/imm_gen_pipe_pkg.sv | 29 ++
 rtl/imm_extract.sv | 41 ++++
 rtl/imm_gen_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the decode-stage immediate generator: format selects,
// XLEN legality check and the storage entry layout.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ILL   = 3'd7
    } imm_sel_e;

    localparam int IMM_MAX_XLEN = 64;

    function automatic bit imm_xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Entries are held at the widest XLEN; the top slices down to its own width.
    typedef struct packed {
        logic [IMM_MAX_XLEN-1:0] imm;
        logic [2:0]              sel;
        logic                    illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction from a 32-bit instruction word.
// Define IMM_GEN_ZICSR_EN to make select 101 produce the Z immediate.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic        s;
    logic [63:0] imm64;
    logic        unused_bits;

    assign s = instr[31];

    // Built at 64 bits and sliced, so sign extension is uniform for both widths.
    always_comb begin
        imm64   = '0;
        illegal = 1'b0;
        case (imm_sel_e'(sel))
            IMM_I:     imm64 = {{52{s}}, instr[31:20]};
            IMM_S:     imm64 = {{52{s}}, instr[31:25], instr[11:7]};
            IMM_B:     imm64 = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm64 = {{32{s}}, instr[31:12], 12'b0};
            IMM_J:     imm64 = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
            IMM_Z:     imm64 = {59'b0, instr[19:15]};
`endif
            IMM_SHAMT: imm64 = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
            default:   illegal = 1'b1;
        endcase
    end

    assign imm         = imm64[XLEN-1:0];
    assign unused_bits = ^{instr[6:0], imm64};

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one-cycle extract into a main output
// register backed by a skid register, with flush and illegal-select counter.
// Optional Z immediate enabled by IMM_GEN_ZICSR_EN.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_sel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    if (!imm_xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] ext_imm;
    logic            ext_ill;
    imm_entry_t      new_e;
    imm_entry_t      main_q, main_d, skid_q, skid_d;
    logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            acc, drain;
    logic            unused_bits;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .sel     (in_sel),
        .imm     (ext_imm),
        .illegal (ext_ill)
    );

    always_comb begin
        new_e               = '0;
        new_e.imm[XLEN-1:0] = ext_imm;
        new_e.sel           = in_sel;
        new_e.illegal       = ext_ill;
    end

    // in_ready depends only on skid state, so there is no path from out_ready.
    assign acc   = in_valid && !skid_vld_q && !flush;
    assign drain = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if (drain) begin
                if (skid_vld_q) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end else if (acc) begin
                    main_d = new_e;
                end else begin
                    main_vld_d = 1'b0;
                end
            end else if (acc) begin
                if (!main_vld_q) begin
                    main_d     = new_e;
                    main_vld_d = 1'b1;
                end else begin
                    skid_d     = new_e;
                    skid_vld_d = 1'b1;
                end
            end
            if (acc && new_e.illegal && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = !skid_vld_q;
    assign out_valid   = main_vld_q;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_sel     = main_q.sel;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;
    assign unused_bits = ^{main_q.imm, skid_q.imm};

endmodule
